// File: rtl/z2_bus_sm.sv
// Zorro II slave bus-cycle state machine: strobe synchronisers, optional wait-state counter, DTACK/OE generation.
// Define Z2_WAITSTATE_EN to enable the FLASH_WS/IDE_WS wait-state counter; otherwise all targets complete with zero waits.
module z2_bus_sm #(
    parameter int unsigned FLASH_WS = 2,
    parameter int unsigned IDE_WS   = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AS_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic       ram_access,
    input  logic       ide_access,
    input  logic       ctrl_access,
    input  logic       flash_access,
    input  logic       autoconfig_cycle,
    input  logic       ac_dtack,
    output logic [1:0] z2_state,
    output logic       DTACK_n,
    output logic       dtack_oe,
    output logic       data_oe,
    output logic       wr_strobe
);

    localparam int unsigned SYNC_W = 2;
    localparam int unsigned WS_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_END   = 2'b11
    } state_t;

    state_t              r_state;
    logic [SYNC_W-1:0]   r_as_sync;
    logic [SYNC_W-1:0]   r_ds_sync;
    logic [SYNC_W-1:0]   r_sync_vld;
    logic                r_rearm_wait;
    logic                r_rw;

    logic                w_as_s;
    logic                w_ds_s;
    logic                w_hit;
    logic                w_ws_done;
    logic                w_start_to_data;

    // Two-flop synchronisers; r_sync_vld marks when their outputs reflect post-reset pin values.
    always_ff @(posedge CLK or posedge RESET) begin : p_sync
        if (RESET) begin
            r_as_sync  <= '0;
            r_ds_sync  <= '0;
            r_sync_vld <= '0;
        end else begin
            r_as_sync  <= {r_as_sync[0], ~AS_n};
            r_ds_sync  <= {r_ds_sync[0], ~UDS_n | ~LDS_n};
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    assign w_as_s          = r_as_sync[SYNC_W-1];
    assign w_ds_s          = r_ds_sync[SYNC_W-1];
    assign w_hit           = ram_access | ide_access | ctrl_access | flash_access | autoconfig_cycle;
    assign w_start_to_data = (r_state == ST_START) && w_as_s && w_ds_s;

`ifdef Z2_WAITSTATE_EN
    logic [WS_W-1:0] r_ws_cnt;
    logic [WS_W-1:0] w_ws_load;

    // Flash wins over IDE when both decodes hit.
    always_comb begin : p_ws_load
        w_ws_load = '0;
        if (flash_access) begin
            w_ws_load = WS_W'(FLASH_WS);
        end else if (ide_access) begin
            w_ws_load = WS_W'(IDE_WS);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin : p_ws_cnt
        if (RESET) begin
            r_ws_cnt <= '0;
        end else if (w_start_to_data) begin
            r_ws_cnt <= w_ws_load;
        end else if ((r_state == ST_DATA) && w_as_s && (r_ws_cnt != '0)) begin
            r_ws_cnt <= r_ws_cnt - WS_W'(1);
        end
    end

    assign w_ws_done = (r_ws_cnt == '0);
`else
    logic w_unused_ws;

    // Wait-state parameters have no effect without the counter.
    assign w_unused_ws = ^{WS_W'(FLASH_WS), WS_W'(IDE_WS)};
    assign w_ws_done   = 1'b1;
`endif

    // Bus-cycle FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge CLK or posedge RESET) begin : p_fsm
        if (RESET) begin
            r_state      <= ST_IDLE;
            DTACK_n      <= 1'b1;
            dtack_oe     <= 1'b0;
            data_oe      <= 1'b0;
            wr_strobe    <= 1'b0;
            r_rw         <= 1'b1;
            r_rearm_wait <= 1'b1;
        end else begin
            wr_strobe <= 1'b0;

            // After reset, a strobe already low must be seen released before a cycle may start.
            if (r_sync_vld[SYNC_W-1] && !w_as_s) begin
                r_rearm_wait <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_as_s && w_hit && !r_rearm_wait) begin
                        r_state  <= ST_START;
                        dtack_oe <= 1'b1;
                        r_rw     <= RW;
                    end
                end
                ST_START: begin
                    if (!w_as_s) begin
                        r_state  <= ST_IDLE;
                        dtack_oe <= 1'b0;
                    end else if (w_ds_s) begin
                        r_state   <= ST_DATA;
                        data_oe   <= r_rw;
                        wr_strobe <= ~r_rw;
                    end
                end
                ST_DATA: begin
                    if (!w_as_s) begin
                        r_state  <= ST_IDLE;
                        dtack_oe <= 1'b0;
                        data_oe  <= 1'b0;
                    end else if (w_ws_done && (!autoconfig_cycle || ac_dtack)) begin
                        r_state <= ST_END;
                        DTACK_n <= 1'b0;
                    end
                end
                ST_END: begin
                    if (!w_as_s) begin
                        r_state  <= ST_IDLE;
                        DTACK_n  <= 1'b1;
                        dtack_oe <= 1'b0;
                        data_oe  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign z2_state = r_state;

endmodule

// File: tb/tb_z2_bus_sm.sv
// Randomised bench for z2_bus_sm: each bus cycle is turned into an expected state timeline from its timing parameters.
module tb_z2_bus_sm;

    localparam int unsigned FLASH_WS = 2;
    localparam int unsigned IDE_WS   = 3;
    localparam int MAXE = 4096;
    localparam int INF  = 1000;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       AS_n, UDS_n, LDS_n, RW;
    logic       ram_access, ide_access, ctrl_access, flash_access, autoconfig_cycle, ac_dtack;
    logic [1:0] z2_state;
    logic       DTACK_n, dtack_oe, data_oe, wr_strobe;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    logic [1:0] exp_state [MAXE];
    bit         exp_vld   [MAXE];
    bit         exp_rd    [MAXE];
    bit         exp_wr    [MAXE];

    int obs_base    = 1 << 30;
    int obs_data    = 0;
    int obs_wr      = 0;
    int obs_busy    = 0;
    int obs_dtack_e = -1;

    z2_bus_sm #(.FLASH_WS(FLASH_WS), .IDE_WS(IDE_WS)) dut (
        .CLK(CLK), .RESET(RESET),
        .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
        .ram_access(ram_access), .ide_access(ide_access), .ctrl_access(ctrl_access),
        .flash_access(flash_access), .autoconfig_cycle(autoconfig_cycle), .ac_dtack(ac_dtack),
        .z2_state(z2_state), .DTACK_n(DTACK_n), .dtack_oe(dtack_oe),
        .data_oe(data_oe), .wr_strobe(wr_strobe)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, $signed(act), $signed(req), edge_cnt);
        end
    endtask

    // Edge e counts from the first edge that samples the new strobes; as_s is true for edges 3..2+x.
    function automatic logic [1:0] model_state(int e, bit hit, int x, int d_edge, int e_edge);
        if (!hit || e < 3 || e >= 3 + x) return 2'd0;
        if (e < d_edge) return 2'd1;
        if (e < e_edge) return 2'd2;
        return 2'd3;
    endfunction

    // tgt: 0 none, 1 ram, 2 ide, 3 ctrl, 4 flash, 5 autoconfig, 6 flash+ide.
    // d: DS delay after AS, x: AS low cycles, g: AS high gap (>=2), a: ac_dtack edges after DATA entry.
    task automatic run_txn(input int tgt, input bit rw, input int d, input int x, input int g, input int a);
        int         base, w, d_edge, e_edge, ac_k;
        bit         hit, ac_on, dsl;
        logic [1:0] ds_sel, st;
        base = edge_cnt;
        hit  = (tgt != 0);
        w    = 0;
`ifdef Z2_WAITSTATE_EN
        if (tgt == 4 || tgt == 6) w = FLASH_WS;
        else if (tgt == 2)        w = IDE_WS;
`endif
        d_edge = (d < x) ? ((d > 1) ? 3 + d : 4) : INF;
        ac_k   = d_edge + a - 1;
        ac_on  = (tgt == 5) && (ac_k < x + g);
        if (tgt == 5) e_edge = ac_on ? d_edge + a : INF;
        else          e_edge = d_edge + w + 1;
        ds_sel = 2'($urandom_range(1, 3));

        for (int e = 1; e <= x + g; e++) begin
            if (base + e < MAXE) begin
                st = model_state(e, hit, x, d_edge, e_edge);
                exp_vld[base + e]   = 1'b1;
                exp_state[base + e] = st;
                exp_rd[base + e]    = rw;
                exp_wr[base + e]    = !rw && (st == 2'd2) && (e == d_edge);
            end
        end

        obs_base = base; obs_data = 0; obs_wr = 0; obs_busy = 0; obs_dtack_e = -1;
        ram_access       = (tgt == 1);
        ide_access       = (tgt == 2) || (tgt == 6);
        ctrl_access      = (tgt == 3);
        flash_access     = (tgt == 4) || (tgt == 6);
        autoconfig_cycle = (tgt == 5);
        RW               = rw;
        for (int k = 0; k < x + g; k++) begin
            AS_n     = !(k < x);
            dsl      = (k >= d) && (k < x);
            UDS_n    = !(dsl && ds_sel[0]);
            LDS_n    = !(dsl && ds_sel[1]);
            ac_dtack = ac_on && (k == ac_k);
            @(negedge CLK);
        end
        ac_dtack = 1'b0;
    endtask

    // Per-edge comparison against the timeline, plus running statistics for the directed pins.
    always @(posedge CLK) begin : p_compare
        int ec;
        edge_cnt++;
        ec = edge_cnt;
        #1;
        if (ec > obs_base) begin
            if (z2_state == 2'd2) obs_data++;
            if (wr_strobe)        obs_wr++;
            if (dtack_oe)         obs_busy++;
            if (!DTACK_n && obs_dtack_e < 0) obs_dtack_e = ec - obs_base;
        end
        if (ec < MAXE && exp_vld[ec]) begin
            chk("z2_state", 32'(z2_state), 32'(exp_state[ec]));
            chk("DTACK_n",  32'(DTACK_n),  32'(exp_state[ec] != 2'd3));
            chk("dtack_oe", 32'(dtack_oe), 32'(exp_state[ec] != 2'd0));
            chk("data_oe",  32'(data_oe),  32'(exp_rd[ec] && exp_state[ec][1]));
            chk("wr_strobe", 32'(wr_strobe), 32'(exp_wr[ec]));
        end
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        bit seen;
        int busy;
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        ram_access = 1'b0; ide_access = 1'b0; ctrl_access = 1'b0;
        flash_access = 1'b0; autoconfig_cycle = 1'b0; ac_dtack = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_state",    32'(z2_state),  32'd0);
        chk("rst_dtack_n",  32'(DTACK_n),   32'd1);
        chk("rst_dtack_oe", 32'(dtack_oe),  32'd0);
        chk("rst_data_oe",  32'(data_oe),   32'd0);
        chk("rst_wr",       32'(wr_strobe), 32'd0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);

        // RAM read, zero waits: DTACK_n falls 4 edges after the sampling edge.
        run_txn(1, 1'b1, 0, 8, 3, 0);
        chk("ram_rd_latency", 32'(obs_dtack_e), 32'd5);
        chk("ram_rd_data",    32'(obs_data),    32'd1);

        run_txn(4, 1'b0, 0, 10, 3, 0);
        chk("flash_wr_strobes", 32'(obs_wr), 32'd1);
`ifdef Z2_WAITSTATE_EN
        chk("flash_wr_data", 32'(obs_data), 32'd3);
`else
        chk("flash_wr_data", 32'(obs_data), 32'd1);
`endif

        // Autoconfig read with ac_dtack 3 edges after DATA entry.
        run_txn(5, 1'b1, 0, 10, 3, 3);
        chk("ac_rd_data",    32'(obs_data),    32'd3);
        chk("ac_rd_latency", 32'(obs_dtack_e), 32'd7);

        run_txn(2, 1'b1, 0, 2, 3, 0);
        chk("ide_abort_dtack", 32'(obs_dtack_e), 32'hFFFF_FFFF);
        chk("ide_abort_busy",  32'(obs_busy),    32'd2);

        run_txn(0, 1'b1, 0, 6, 3, 0);
        chk("nohit_busy", 32'(obs_busy), 32'd0);

        for (int i = 0; i < 80; i++) begin
            run_txn(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 12)),
                    int'($urandom_range(2, 4)), int'($urandom_range(1, 4)));
        end

        // Reset while in END with AS_n held low.
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b1; RW = 1'b1;
        ram_access = 1'b1; ide_access = 1'b0; ctrl_access = 1'b0;
        flash_access = 1'b0; autoconfig_cycle = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge CLK); #1;
            if (DTACK_n === 1'b0) seen = 1'b1;
        end
        chk("rst_mid_reach_end", 32'(seen), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("rst_mid_dtack_n",  32'(DTACK_n),  32'd1);
        chk("rst_mid_dtack_oe", 32'(dtack_oe), 32'd0);
        chk("rst_mid_state",    32'(z2_state), 32'd0);
        @(negedge CLK) RESET = 1'b0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (z2_state != 2'd0 || dtack_oe) busy++;
        end
        chk("rst_held_as_blocked", 32'(busy), 32'd0);
        @(negedge CLK) begin AS_n = 1'b1; UDS_n = 1'b1; end
        repeat (3) @(negedge CLK);
        AS_n = 1'b0; UDS_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge CLK); #1;
            if (z2_state == 2'd1) seen = 1'b1;
        end
        chk("rst_rearm_start", 32'(seen), 32'd1);
        @(negedge CLK) begin AS_n = 1'b1; UDS_n = 1'b1; ram_access = 1'b0; end
        repeat (5) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z2_bus_sm.md
Z2_BUS_SM -- requirements
Module: z2_bus_sm

Interface
REQ-001 Parameter FLASH_WS, default 2: wait cycles inserted in DATA for flash_access cycles (4-bit range 0..15).
REQ-002 Parameter IDE_WS, default 3: wait cycles inserted in DATA for ide_access cycles (4-bit range 0..15).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 AS_n, UDS_n, LDS_n  input  1 each  raw Zorro II address/data strobes, active low, asynchronous to CLK.
REQ-006 RW  input  1  bus direction, 1 = read.
REQ-007 ram_access, ide_access, ctrl_access, flash_access, autoconfig_cycle  input  1 each  address decode hits from the autoconfig block.
REQ-008 ac_dtack  input  1  one-cycle completion pulse from the autoconfig block.
REQ-009 z2_state  output  2  bus cycle state: IDLE=00, START=01, DATA=10, END=11 (matches the Z2_* encoding in globalparams.vh).
REQ-010 DTACK_n  output  1  registered data acknowledge, active low.
REQ-011 dtack_oe  output  1  DTACK pin drive enable.
REQ-012 data_oe  output  1  data bus drive enable for reads.
REQ-013 wr_strobe  output  1  single-cycle write-data capture pulse.

Function
REQ-014 AS_n, UDS_n and LDS_n SHALL each pass through a 2-flop synchronizer; as_s = synchronized !AS_n; ds_s = synchronized (!UDS_n | !LDS_n).
REQ-015 hit = ram_access | ide_access | ctrl_access | flash_access | autoconfig_cycle, sampled combinationally each cycle.
REQ-016 IDLE -> START when as_s & hit; as_s & !hit stays IDLE, no drive on any output.
REQ-017 START -> DATA when ds_s; on this transition the wait counter SHALL load FLASH_WS (flash), IDE_WS (ide), else 0; flash has priority over ide when both are set.
REQ-018 START -> DATA with RW=0 SHALL pulse wr_strobe high for exactly the first DATA cycle.
REQ-019 DATA: counter nonzero -> decrement; counter zero and !autoconfig_cycle -> END; counter zero and autoconfig_cycle -> END only in the cycle ac_dtack=1.
REQ-020 Entry to END SHALL drive DTACK_n=0 on the same edge; DTACK_n SHALL stay 0 throughout END.
REQ-021 dtack_oe SHALL be 1 in START, DATA and END, 0 in IDLE.
REQ-022 data_oe SHALL be 1 in DATA and END when RW=1, else 0.
REQ-023 END -> IDLE when !as_s; on that edge DTACK_n<=1 and dtack_oe<=0.
REQ-024 !as_s in START or DATA (aborted cycle) SHALL return to IDLE next edge without asserting DTACK_n or wr_strobe.
REQ-025 A new cycle SHALL NOT begin until at least one IDLE cycle follows END (back-to-back AS_n low blocked by REQ-023).
REQ-026 Minimum read latency, AS_n/DS low to DTACK_n low, zero-wait target: 2 sync + START + DATA = 4 CLK edges.

Reset
REQ-027 RESET=1 SHALL asynchronously force z2_state=IDLE, DTACK_n=1, dtack_oe=0, data_oe=0, wr_strobe=0, counter=0, synchronizer flops to deasserted.
REQ-028 RESET asserted mid-cycle SHALL release DTACK immediately; after deassertion the FSM SHALL wait for as_s to go low and high again before starting a new cycle.

Configuration
REQ-029 Macro Z2_WAITSTATE_EN: when defined, wait counter behaves per REQ-017/019; when undefined, counter is removed, all targets complete with zero wait states, FLASH_WS/IDE_WS ignored.

Verification
REQ-030 RAM read: AS_n/UDS_n low, RW=1, ram_access=1 -> z2_state 00,01,10,11; DTACK_n low 4 edges after strobes; data_oe=1 in DATA/END; release on AS_n high.
REQ-031 Flash write, FLASH_WS=2, Z2_WAITSTATE_EN defined -> wr_strobe one cycle, 3 DATA cycles, then DTACK_n=0; undefined -> 1 DATA cycle.
REQ-032 Autoconfig read, ac_dtack delayed 3 cycles after DATA entry -> FSM holds DATA until ac_dtack, END next edge.
REQ-033 AS_n high during DATA of IDE_WS=3 cycle -> IDLE next edge, DTACK_n never 0, dtack_oe drops.
REQ-034 AS_n low with all access inputs 0 -> z2_state stays 00, dtack_oe=0 for whole cycle.
REQ-035 RESET pulsed in END -> DTACK_n=1 immediately; with AS_n still low after reset, no new cycle until AS_n high then low.
